mcm_interp_pipe: RTL and testbench

- Parametrised, pipelined multiplierless (shift-add) interpolation engine for the intra angular datapath.
- Processes NUM_LANES reference-sample lanes per beat, all lanes sharing one fractional position.
- Two modes:
  - mode 0: 2-tap linear fractional interpolation.
  - mode 1: 3-tap [1 2 1] smoothing.
- Sits between the reference-sample buffer and the prediction writer; uses a valid/ready stream on both sides.

---
 rtl/mcm_interp_pipe.sv | 172 +++++++++++++++++
 tb/tb_mcm_interp_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcm_interp_pipe.sv
// rtl/mcm_interp_pipe.sv - 3-stage shift-add angular interpolation pipe (linear / [1 2 1] smoothing)
// Optional perf counters: define MCM_INTERP_PIPE_PERF_CNT_EN.
module mcm_interp_pipe #(
    parameter int BIT_DEPTH = 8,
    parameter int NUM_LANES = 4,
    parameter int FRAC_BITS = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_mode,
    input  logic [FRAC_BITS-1:0]           in_frac,
    input  logic [NUM_LANES*BIT_DEPTH-1:0] in_s0,
    input  logic [NUM_LANES*BIT_DEPTH-1:0] in_s1,
    input  logic [NUM_LANES*BIT_DEPTH-1:0] in_s2,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES*BIT_DEPTH-1:0] out_pred
`ifdef MCM_INTERP_PIPE_PERF_CNT_EN
    ,
    output logic [31:0]                    perf_beats,
    output logic [31:0]                    perf_stalls
`endif
);

    localparam int IW = BIT_DEPTH + FRAC_BITS + 1;
    localparam int DW = NUM_LANES * BIT_DEPTH;
    localparam int TW = NUM_LANES * IW;
    localparam logic [FRAC_BITS:0] W_VAL      = {1'b1, {FRAC_BITS{1'b0}}};
    localparam logic [IW-1:0]      HALF_W     = IW'(1) << (FRAC_BITS - 1);
    localparam logic [IW-1:0]      SMOOTH_RND = IW'(2);

    // Product of a sample and a weight built from shifted copies only.
    function automatic logic [IW-1:0] shift_add(input logic [BIT_DEPTH-1:0] x,
                                                input logic [FRAC_BITS:0]   w);
        logic [IW-1:0] acc;
        acc = '0;
        for (int k = 0; k <= FRAC_BITS; k++) begin
            if (w[k]) begin
                acc = acc + (IW'(x) << k);
            end
        end
        return acc;
    endfunction

    logic v1, v2, v3;
    logic load1, load2, load3;

    assign load3     = !v3 | out_ready;
    assign load2     = !v2 | load3;
    assign load1     = !v1 | load2;
    assign in_ready  = load1;
    assign out_valid = v3;

    // Stage 1: raw capture
    logic                 m1;
    logic [FRAC_BITS-1:0] f1;
    logic [DW-1:0]        s0_r, s1_r, s2_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            m1   <= 1'b0;
            f1   <= '0;
            s0_r <= '0;
            s1_r <= '0;
            s2_r <= '0;
        end else if (load1) begin
            v1 <= in_valid;
            if (in_valid) begin
                m1   <= in_mode;
                f1   <= in_frac;
                s0_r <= in_s0;
                s1_r <= in_s1;
                s2_r <= in_s2;
            end
        end
    end

    // Stage 2: weighted terms; W - f via two's complement in FRAC_BITS+1 bits
    logic [FRAC_BITS:0] wf;
    logic [TW-1:0]      t0_d, t1_d, t2_d;

    assign wf = W_VAL + ~{1'b0, f1} + {{FRAC_BITS{1'b0}}, 1'b1};

    always_comb begin
        t0_d = '0;
        t1_d = '0;
        t2_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (m1) begin
                t0_d[i*IW +: IW] = IW'(s0_r[i*BIT_DEPTH +: BIT_DEPTH]);
                t1_d[i*IW +: IW] = IW'(s1_r[i*BIT_DEPTH +: BIT_DEPTH]) << 1;
                t2_d[i*IW +: IW] = IW'(s2_r[i*BIT_DEPTH +: BIT_DEPTH]);
            end else begin
                t0_d[i*IW +: IW] = shift_add(s0_r[i*BIT_DEPTH +: BIT_DEPTH], wf);
                t1_d[i*IW +: IW] = shift_add(s1_r[i*BIT_DEPTH +: BIT_DEPTH], {1'b0, f1});
            end
        end
    end

    logic          m2;
    logic [TW-1:0] t0_r, t1_r, t2_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            m2   <= 1'b0;
            t0_r <= '0;
            t1_r <= '0;
            t2_r <= '0;
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                m2   <= m1;
                t0_r <= t0_d;
                t1_r <= t1_d;
                t2_r <= t2_d;
            end
        end
    end

    // Stage 3: final add, round, shift
    logic [IW-1:0] rnd;
    logic [TW-1:0] sum_d;
    logic [DW-1:0] pred_d;

    assign rnd = m2 ? SMOOTH_RND : HALF_W;

    always_comb begin
        sum_d  = '0;
        pred_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            sum_d[i*IW +: IW] = t0_r[i*IW +: IW] + t1_r[i*IW +: IW] + t2_r[i*IW +: IW] + rnd;
            if (m2) begin
                pred_d[i*BIT_DEPTH +: BIT_DEPTH] = BIT_DEPTH'(sum_d[i*IW +: IW] >> 2);
            end else begin
                pred_d[i*BIT_DEPTH +: BIT_DEPTH] = BIT_DEPTH'(sum_d[i*IW +: IW] >> FRAC_BITS);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3       <= 1'b0;
            out_pred <= '0;
        end else if (load3) begin
            v3 <= v2;
            if (v2) begin
                out_pred <= pred_d;
            end
        end
    end

`ifdef MCM_INTERP_PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_beats  <= '0;
            perf_stalls <= '0;
        end else begin
            if (v3 && out_ready) begin
                perf_beats <= perf_beats + 32'd1;
            end
            if (v3 && !out_ready) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mcm_interp_pipe.sv
// tb/tb_mcm_interp_pipe.sv - randomized + directed bench for mcm_interp_pipe against an arithmetic model
module tb_mcm_interp_pipe;

    localparam int B  = 8;
    localparam int N  = 4;
    localparam int F  = 5;
    localparam int DW = N * B;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [F-1:0]  in_frac;
    logic [DW-1:0] in_s0, in_s1, in_s2;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_pred;
`ifdef MCM_INTERP_PIPE_PERF_CNT_EN
    logic [31:0]   perf_beats;
    logic [31:0]   perf_stalls;
`endif

    mcm_interp_pipe #(.BIT_DEPTH(B), .NUM_LANES(N), .FRAC_BITS(F)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_frac   (in_frac),
        .in_s0     (in_s0),
        .in_s1     (in_s1),
        .in_s2     (in_s2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pred  (out_pred)
`ifdef MCM_INTERP_PIPE_PERF_CNT_EN
        ,
        .perf_beats  (perf_beats),
        .perf_stalls (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            vectors    = 0;
    int            miscompares = 0;
    int            popped     = 0;
    bit            accepted   = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_pred  = '0;
    logic [DW-1:0] expq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_model(input bit mode, input int f,
                                                input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [DW-1:0] c);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int x0, x1, x2, p;
            x0 = int'(a[i*B +: B]);
            x1 = int'(b[i*B +: B]);
            x2 = int'(c[i*B +: B]);
            if (mode) p = (x0 + 2 * x1 + x2 + 2) / 4;
            else      p = (((1 << F) - f) * x0 + f * x1 + (1 << (F - 1))) / (1 << F);
            r[i*B +: B] = B'(p);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] fill(input int v);
        logic [DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*B +: B] = B'(v);
        return r;
    endfunction

    // Observe one cycle (1 ns after the falling edge), then advance to the next falling edge.
    task automatic tick();
        #1;
        if (prev_stall) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_pred", 64'(out_pred), 64'(prev_pred));
        end
        if (out_valid && out_ready) begin
            if (expq.size() == 0) check("spurious_out", 64'(out_valid), 64'd0);
            else                  check("pred", 64'(out_pred), 64'(expq.pop_front()));
            popped++;
        end
        accepted = in_valid && in_ready;
        if (accepted) expq.push_back(ref_model(in_mode, int'(in_frac), in_s0, in_s1, in_s2));
        prev_stall = out_valid && !out_ready;
        prev_pred  = out_pred;
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        in_mode = 1'($urandom_range(0, 1));
        in_frac = F'($urandom_range(0, (1 << F) - 1));
        in_s0   = DW'($urandom);
        in_s1   = DW'($urandom);
        in_s2   = DW'($urandom);
    endtask

    task automatic one_beat(input string tag, input bit mode, input int f,
                            input int a, input int b, input int c, input int expv);
        bit seen;
        seen      = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = mode;
        in_frac   = F'(f);
        in_s0     = fill(a);
        in_s1     = fill(b);
        in_s2     = fill(c);
        tick();
        check({tag, "_accept"}, 64'(accepted), 64'd1);
        in_valid = 1'b0;
        rand_inputs();
        for (int k = 1; k <= 8 && !seen; k++) begin
            #1;
            if (out_valid) begin
                seen = 1;
                check({tag, "_latency"}, 64'(k), 64'd3);
                check(tag, 64'(out_pred), 64'(fill(expv)));
            end
            tick();
        end
        if (!seen) check({tag, "_timeout"}, 64'(out_valid), 64'd1);
    endtask

    initial begin
        int sent, p0, c;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_mode   = 1'b0;
        in_frac   = '0;
        in_s0     = '0;
        in_s1     = '0;
        in_s2     = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pred", 64'(out_pred), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef MCM_INTERP_PIPE_PERF_CNT_EN
        sent = 0;
        c    = 0;
        while ((sent < 5 || expq.size() != 0) && c < 40) begin
            in_valid  = (sent < 5);
            out_ready = !(c >= 3 && c <= 5);
            rand_inputs();
            tick();
            if (accepted) sent++;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("perf_beats", 64'(perf_beats), 64'd5);
        check("perf_stalls", 64'(perf_stalls), 64'd3);
`endif

        one_beat("lin_f16", 1'b0, 16, 100, 200, 0, 150);
        one_beat("lin_f0", 1'b0, 0, 37, 255, 0, 37);
        one_beat("lin_f31", 1'b0, 31, 0, 255, 0, 247);
        one_beat("smooth", 1'b1, 0, 10, 20, 31, 20);
        one_beat("smooth_max", 1'b1, 0, 255, 255, 255, 255);
        one_beat("lin_max", 1'b0, 7, 255, 255, 255, 255);

        // Eight-beat stream with the sink stalled for four cycles
        p0   = popped;
        sent = 0;
        c    = 0;
        while ((sent < 8 || expq.size() != 0) && c < 60) begin
            in_valid  = (sent < 8);
            out_ready = !(c >= 4 && c <= 7);
            rand_inputs();
            if (c >= 4 && c <= 7) begin
                #1;
                check("full_in_ready", 64'(in_ready), 64'd0);
            end
            tick();
            if (accepted) sent++;
            c++;
        end
        check("stream_count", 64'(popped - p0), 64'd8);

        // Reset with two beats in flight, the oldest already presented
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rand_inputs();
        tick();
        rand_inputs();
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        #1;
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_pred", 64'(out_pred), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        expq.delete();
        prev_stall = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        p0 = popped;
        one_beat("post_reset", 1'b0, 8, 40, 80, 0, 50);
        repeat (6) tick();
        check("post_reset_count", 64'(popped - p0), 64'd1);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_inputs();
            if ($urandom_range(0, 7) == 0) in_frac = '0;
            if ($urandom_range(0, 7) == 0) in_frac = '1;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        check("drain_empty", 64'(expq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
